// File: rtl/inst_loader.sv
// inst_loader: boot-time program loader (write side of the instruction memory).
// Accepts a byte stream over a valid/ready handshake and assembles big-endian
// 32-bit words, where the first byte is bits [31:24]. Words are written to
// sequential instruction-memory addresses starting at 0. The core is held in
// reset while a load is in progress. On completion the loader pulses done and
// reports an XOR checksum of the loaded image.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   start, num_words    begin a session with a word count (clamped to 2**IW)
//   byte_valid/_data    input byte stream
//   byte_ready          loader accepts a byte this cycle
//   wr_en/addr/data     instruction-memory write port, one strobe per word
//   busy, cpu_hold      session in progress (cpu_hold mirrors busy)
//   done                one-cycle completion pulse
//   csum                XOR of all words written this session
module inst_loader #(
   parameter int unsigned IW = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [IW:0]   num_words,
   input  logic          byte_valid,
   input  logic [7:0]    byte_data,
   output logic          byte_ready,
   output logic          wr_en,
   output logic [IW-1:0] wr_addr,
   output logic [31:0]   wr_data,
   output logic          busy,
   output logic          cpu_hold,
   output logic          done,
   output logic [31:0]   csum
);

   typedef enum logic [1:0] {StIdle, StRecv, StWrite, StDone} state_e;

   localparam logic [IW:0] MaxWords = {1'b1, {IW{1'b0}}};

   state_e      state;
   logic [IW:0] count;
   logic [IW:0] word_idx;
   logic [IW:0] word_next;
   logic [1:0]  byte_idx;
   // Holds bytes 0..2 of the current word; byte 3 is merged directly on write.
   // Shifting left puts byte 0 in the top lane once all four bytes are in.
   logic [23:0] shreg;

   assign word_next = word_idx + {{IW{1'b0}}, 1'b1};

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= StIdle;
         count      <= '0;
         word_idx   <= '0;
         byte_idx   <= '0;
         shreg      <= '0;
         byte_ready <= 1'b0;
         wr_en      <= 1'b0;
         wr_addr    <= '0;
         wr_data    <= '0;
         done       <= 1'b0;
         csum       <= '0;
      end else begin
         unique case (state)
            StIdle: begin
               if (start) begin
                  csum     <= '0;
                  word_idx <= '0;
                  byte_idx <= '0;
                  count    <= (num_words > MaxWords) ? MaxWords : num_words;
                  if (num_words == '0) begin
                     state <= StDone;
                     done  <= 1'b1;
                  end else begin
                     state      <= StRecv;
                     byte_ready <= 1'b1;
                  end
               end
            end
            StRecv: begin
               if (byte_valid && byte_ready) begin
                  byte_idx <= byte_idx + 2'd1;
                  if (byte_idx == 2'd3) begin
                     state      <= StWrite;
                     byte_ready <= 1'b0;
                     wr_en      <= 1'b1;
                     wr_addr    <= word_idx[IW-1:0];
                     wr_data    <= {shreg, byte_data};
                  end else begin
                     shreg <= {shreg[15:0], byte_data};
                  end
               end
            end
            StWrite: begin
               wr_en    <= 1'b0;
               csum     <= csum ^ wr_data;
               word_idx <= word_next;
               // Full-width compare so a count of 2**IW ends at address 2**IW-1.
               if (word_next == count) begin
                  state <= StDone;
                  done  <= 1'b1;
               end else begin
                  state      <= StRecv;
                  byte_ready <= 1'b1;
               end
            end
            StDone: begin
               done  <= 1'b0;
               state <= StIdle;
            end
            default: state <= StIdle;
         endcase
      end
   end

   assign busy     = (state != StIdle);
   assign cpu_hold = busy;

endmodule

// File: tb/tb_inst_loader.sv
// Self-checking bench for inst_loader. A transaction-level model predicts the
// outputs for each cycle from the handshake rules. A single negedge process
// compares the DUT against that model. Directed tests add literal expectations.
module tb_inst_loader;
   localparam int unsigned IW = 4;

   logic          clk;
   logic          reset;
   logic          start;
   logic [IW:0]   num_words;
   logic          byte_valid;
   logic [7:0]    byte_data;
   logic          byte_ready;
   logic          wr_en;
   logic [IW-1:0] wr_addr;
   logic [31:0]   wr_data;
   logic          busy;
   logic          cpu_hold;
   logic          done;
   logic [31:0]   csum;

   inst_loader #(.IW(IW)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .num_words  (num_words),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .byte_ready (byte_ready),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .busy       (busy),
      .cpu_hold   (cpu_hold),
      .done       (done),
      .csum       (csum)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model state: expected outputs for the current cycle.
   bit          armed    = 1'b0;
   bit          m_busy   = 1'b0;
   bit          m_ready  = 1'b0;
   bit          m_wr     = 1'b0;
   bit          m_done   = 1'b0;
   bit          m_rst    = 1'b0;
   int          m_target = 0;
   int          m_widx   = 0;
   int          m_addr   = 0;
   logic [31:0] m_data   = '0;
   logic [31:0] m_csum   = '0;
   byte unsigned m_bytes[$];

   // Observed history.
   logic [31:0] mem [16];
   int wr_cnt    = 0;
   int done_cnt  = 0;
   int busy_cyc  = 0;
   int last_addr = -1;

   always @(negedge clk) begin
      if (armed) begin
         chk("busy", 32'(busy), 32'(m_busy));
         chk("cpu_hold", 32'(cpu_hold), 32'(m_busy));
         chk("byte_ready", 32'(byte_ready), 32'(m_ready));
         chk("wr_en", 32'(wr_en), 32'(m_wr));
         chk("done", 32'(done), 32'(m_done));
         chk("csum", csum, m_csum);
         if (m_wr) begin
            chk("wr_addr", 32'(wr_addr), 32'(m_addr));
            chk("wr_data", wr_data, m_data);
         end
         if (m_rst) begin
            chk("wr_addr_reset", 32'(wr_addr), 32'd0);
            chk("wr_data_reset", wr_data, 32'd0);
         end
         if (wr_en) begin
            mem[wr_addr] = wr_data;
            wr_cnt++;
            last_addr = int'(wr_addr);
         end
         if (done) done_cnt++;
         if (busy) busy_cyc++;
      end
      // Advance the model with the inputs the next rising edge will sample.
      m_rst = reset;
      if (reset) begin
         armed   = 1'b1;
         m_busy  = 1'b0;
         m_ready = 1'b0;
         m_wr    = 1'b0;
         m_done  = 1'b0;
         m_csum  = '0;
         m_bytes.delete();
      end else if (m_done) begin
         m_done = 1'b0;
         m_busy = 1'b0;
      end else if (m_wr) begin
         m_csum = m_csum ^ m_data;
         m_widx++;
         m_wr = 1'b0;
         if (m_widx == m_target) m_done = 1'b1;
         else m_ready = 1'b1;
      end else if (m_ready) begin
         if (byte_valid) begin
            m_bytes.push_back(byte_data);
            if (m_bytes.size() == 4) begin
               m_data  = {m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]};
               m_addr  = m_widx;
               m_wr    = 1'b1;
               m_ready = 1'b0;
               m_bytes.delete();
            end
         end
      end else if (!m_busy && start) begin
         m_csum   = '0;
         m_widx   = 0;
         m_target = (int'(num_words) > 16) ? 16 : int'(num_words);
         m_busy   = 1'b1;
         if (m_target == 0) m_done = 1'b1;
         else m_ready = 1'b1;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input int n);
      start     = 1'b1;
      num_words = (IW+1)'(n);
      tick();
      start     = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      bit ok;
      if (gap > 0) begin
         byte_valid = 1'b0;
         repeat (gap) tick();
      end
      byte_valid = 1'b1;
      byte_data  = b;
      ok = 1'b0;
      for (int i = 0; i < 50 && !ok; i++) begin
         ok = byte_ready;
         tick();
      end
      chk("byte_accept", 32'(ok), 32'd1);
      if (gap > 0) byte_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w, input int gap);
      for (int k = 3; k >= 0; k--) send_byte(w[8*k +: 8], gap);
   endtask

   task automatic wait_done();
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         seen = done;
         tick();
      end
      chk("done_seen", 32'(seen), 32'd1);
      tick();
   endtask

   int w0, d0, b0;

   initial begin
      reset = 1'b1; start = 1'b0; num_words = '0; byte_valid = 1'b0; byte_data = '0;
      repeat (2) tick();
      reset = 1'b0;
      tick();

      // Two words, valid held high.
      w0 = wr_cnt; d0 = done_cnt;
      do_start(2);
      send_word(32'h12345678, 0);
      send_word(32'hDEADBEEF, 0);
      byte_valid = 1'b0;
      wait_done();
      chk("t1_csum", csum, 32'hCC99E897);
      chk("t1_mem0", mem[0], 32'h12345678);
      chk("t1_mem1", mem[1], 32'hDEADBEEF);
      chk("t1_writes", 32'(wr_cnt - w0), 32'd2);
      chk("t1_dones", 32'(done_cnt - d0), 32'd1);
      chk("t1_busy_after", 32'(busy), 32'd0);

      // Gapped stream.
      w0 = wr_cnt;
      do_start(1);
      send_word(32'hA5A5A5A5, 3);
      wait_done();
      chk("t2_mem0", mem[0], 32'hA5A5A5A5);
      chk("t2_writes", 32'(wr_cnt - w0), 32'd1);
      chk("t2_csum", csum, 32'hA5A5A5A5);

      // Full depth, count clamped from 31 to 16.
      w0 = wr_cnt;
      do_start(31);
      for (int i = 0; i < 16; i++) send_word(32'(i), 0);
      byte_valid = 1'b0;
      wait_done();
      chk("t3_writes", 32'(wr_cnt - w0), 32'd16);
      chk("t3_last_addr", 32'(last_addr), 32'd15);
      chk("t3_csum", csum, 32'h0);
      for (int i = 0; i < 16; i++) chk("t3_mem", mem[i], 32'(i));

      // Zero-length session.
      w0 = wr_cnt; d0 = done_cnt; b0 = busy_cyc;
      do_start(0);
      repeat (3) tick();
      chk("t4_busy_cycles", 32'(busy_cyc - b0), 32'd1);
      chk("t4_dones", 32'(done_cnt - d0), 32'd1);
      chk("t4_writes", 32'(wr_cnt - w0), 32'd0);
      chk("t4_csum", csum, 32'h0);

      // Reset after two bytes of word 1.
      w0 = wr_cnt;
      do_start(3);
      send_word(32'hAABBCCDD, 0);
      send_byte(8'h11, 0);
      send_byte(8'h22, 0);
      byte_valid = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("t5_busy_rst", 32'(busy), 32'd0);
      chk("t5_ready_rst", 32'(byte_ready), 32'd0);
      chk("t5_csum_rst", csum, 32'h0);
      tick();
      chk("t5_writes", 32'(wr_cnt - w0), 32'd1);
      do_start(1);
      send_word(32'hCAFEF00D, 0);
      byte_valid = 1'b0;
      wait_done();
      chk("t5_mem0", mem[0], 32'hCAFEF00D);
      chk("t5_last_addr", 32'(last_addr), 32'd0);
      chk("t5_csum", csum, 32'hCAFEF00D);

      // start pulsed mid-session is ignored.
      w0 = wr_cnt; d0 = done_cnt;
      do_start(2);
      send_byte(8'h11, 0);
      start = 1'b1;
      num_words = 5'd5;
      send_byte(8'h11, 0);
      start = 1'b0;
      send_byte(8'h11, 0);
      send_byte(8'h11, 0);
      send_word(32'h22222222, 0);
      byte_valid = 1'b0;
      wait_done();
      repeat (3) tick();
      chk("t6_writes", 32'(wr_cnt - w0), 32'd2);
      chk("t6_dones", 32'(done_cnt - d0), 32'd1);
      chk("t6_csum", csum, 32'h33333333);
      chk("t6_busy_after", 32'(busy), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/inst_loader.md
# inst_loader

Boot-time program loader that is the write side of the instruction memory: it accepts a byte stream over a valid/ready handshake, assembles big-endian 32-bit instructions, and writes them to sequential instruction-memory words starting at address 0. It holds the core in reset while loading and reports completion plus an XOR checksum of the loaded image. Byte order matches the hex image layout: the first byte received is bits [31:24].

## Interface
- IW, 4, instruction-memory address width; depth is 2**IW words of 32 bits
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- start  in  1  begin a load session; sampled only in IDLE
- num_words  in  IW+1  words to load, sampled with start; values above 2**IW clamp to 2**IW
- byte_valid  in  1  byte_data is valid
- byte_data  in  8  stream byte
- byte_ready  out  1  loader accepts a byte this cycle
- wr_en  out  1  instruction-memory write strobe, one cycle per word
- wr_addr  out  IW  word address
- wr_data  out  32  assembled instruction
- busy  out  1  session in progress (state != IDLE)
- cpu_hold  out  1  equals busy; keeps the core in reset
- done  out  1  one-cycle completion pulse
- csum  out  32  XOR of all words written this session

## Operation
- States: IDLE, RECV, WRITE, DONE.
- IDLE: byte_ready=0. If start=1 and num_words=0, go to DONE. If start=1 and num_words>0, latch the clamped count, clear word index, byte index and csum, then go to RECV.
- RECV: byte_ready=1. A byte transfers when byte_valid && byte_ready. The shift register takes byte_data into lane 3-byte_idx, so byte 0 lands in [31:24]. byte_idx then increments. On the 4th transfer, go to WRITE.
- WRITE: byte_ready=0 and wr_en=1. wr_addr holds the word index and wr_data holds the assembled word. csum ^= wr_data. The word index increments. If this is the last word, go to DONE; otherwise go to RECV with byte_idx=0.
- DONE: done=1 for exactly one cycle, then go to IDLE. csum holds its value until the next accepted start or reset.
- start outside IDLE is ignored. byte_valid outside RECV is ignored and not consumed.
- The word index saturates logically: with a clamped count of 2**IW, the final address is 2**IW-1. No wrap to 0 occurs within a session.
- Arithmetic: the word counter is IW+1 bits wide. The comparison against the latched count uses the full IW+1 bits.

## Timing
- Reset: state=IDLE, byte_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, cpu_hold=0, done=0, csum=0, internal counters=0.
- Reset mid-session returns to IDLE on the next edge. Words already written are not erased. A partial word is discarded.
- start is accepted at edge N. At N+1: busy=1 and byte_ready=1.
- The 4th byte of a word is accepted at edge M. At M+1: wr_en=1 with valid wr_addr and wr_data; memory captures them at edge M+2. csum reflects the word after edge M+2.
- Minimum cost is 5 cycles per word with byte_valid held high.
- done is high in the cycle after the last WRITE cycle; busy=1 during DONE and drops the cycle after.
- num_words=0: done pulses at N+1, with no writes and csum=0.
- All outputs are registered or decoded directly from registered state; there are no combinational paths from inputs to outputs.

## Test plan
- Load 2 words with bytes 12 34 56 78 DE AD BE EF, valid held high. Required: writes (0, 0x12345678) then (1, 0xDEADBEEF), exactly 2 wr_en pulses, csum=0xCC99E897, one done pulse, busy low after.
- Gapped stream: deassert byte_valid for 3 cycles between every byte of word 0xA5A5A5A5. Required: no bytes lost or duplicated, wr_data=0xA5A5A5A5, and no byte_ready-qualified transfer during WRITE.
- Full depth with IW=4 and num_words=31 (clamped to 16), sending words 0..15 with value = index. Required: addresses 0..15 with no wrap, last wr_addr=15, csum=0x00000000.
- num_words=0: required done at N+1, wr_en never asserted, busy high for exactly 1 cycle.
- Reset asserted after 2 bytes of word 1. Required: the next cycle shows all outputs at reset values and no write of the partial word; a fresh start then loads correctly from address 0.
- start pulsed mid-session with a different num_words. Required: it is ignored; the original count completes and the csum matches the original image.
